// File: rtl/pwm_dec_pkg.sv
// Shared definitions for the PWM bargraph decoder: default widths and
// thresholds, the per-channel brightness class, the tracker state type and
// the duty classifier used by the top level.
package pwm_dec_pkg;

    localparam int unsigned PWM_BITS_DEF    = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned FULL_MIN_DEF    = 200;
    localparam int unsigned MID_MIN_DEF     = 64;
    localparam int unsigned NUM_CH          = 8;

    typedef enum logic [1:0] {
        LVL_OFF  = 2'd0,
        LVL_MID  = 2'd1,
        LVL_FULL = 2'd2
    } level_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    // A duty at or above fullMin is the peak LED, at or above midMin a
    // neighbour, anything below is dark.
    function automatic level_e classify(input int unsigned duty,
                                        input int unsigned fullMin,
                                        input int unsigned midMin);
        level_e lvl;
        if (duty >= fullMin) begin
            lvl = LVL_FULL;
        end else if (duty >= midMin) begin
            lvl = LVL_MID;
        end else begin
            lvl = LVL_OFF;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/pwm_duty_meter.sv
// One channel of duty measurement: synchronises the incoming PWM line,
// counts high cycles over a window and latches the saturated count when the
// shared end-of-window strobe fires.
module pwm_duty_meter
    import pwm_dec_pkg::*;
#(
    parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_i,
    input  logic                win_end_i,
    output logic [PWM_BITS-1:0] duty_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_s;
    logic [PWM_BITS:0]      hi_q;
    logic [PWM_BITS:0]      hi_d;
    logic [PWM_BITS:0]      sum;
    logic [PWM_BITS-1:0]    duty_q;
    logic [PWM_BITS-1:0]    duty_d;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign line_s = sync_q[SYNC_STAGES-1];

    // The last sample of the window is folded in at latch time, so a line
    // held high all window reaches 2^PWM_BITS and is clamped to all-ones.
    always_comb begin
        sum    = hi_q + {{PWM_BITS{1'b0}}, line_s};
        hi_d   = sum;
        duty_d = duty_q;
        if (win_end_i) begin
            hi_d   = '0;
            duty_d = sum[PWM_BITS] ? {PWM_BITS{1'b1}} : sum[PWM_BITS-1:0];
        end
    end

    // High-cycle counter and latched duty registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            duty_q <= '0;
        end else begin
            hi_q   <= hi_d;
            duty_q <= duty_d;
        end
    end

    assign duty_o = duty_q;

endmodule

// File: rtl/pwm_bargraph_decoder.sv
// Receive side of the bouncing-light bargraph: measures the duty of eight
// PWM LED lines per window, finds the single bright LED and tracks its
// position, direction of travel and number of reversals.
// Build option: define NEIGHBOUR_CHECK_EN to also require the LEDs next to
// the peak to be mid-bright and every other LED to be dark.
module pwm_bargraph_decoder
    import pwm_dec_pkg::*;
#(
    parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FULL_MIN    = FULL_MIN_DEF,
    parameter int unsigned MID_MIN     = MID_MIN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          pwm_in,
    input  logic [2:0]          duty_sel,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                frame_done_o,
    output logic [2:0]          pos_o,
    output logic                pos_valid_o,
    output logic                dir_o,
    output logic                moved_o,
    output logic                err_o,
    output logic [7:0]          reversals_o
);

    logic [PWM_BITS-1:0] wcnt_q;
    logic                win_end;
    logic [PWM_BITS-1:0] duty_w [NUM_CH];
    logic                frame_done_q;

    level_e              level [NUM_CH];
    logic [3:0]          full_cnt;
    logic [2:0]          cand_pos;
    logic                nbr_ok;
    logic                frame_valid;
`ifdef NEIGHBOUR_CHECK_EN
    level_e              want;
`endif

    state_e              state_q;
    state_e              state_d;
    logic [2:0]          pos_q;
    logic [2:0]          pos_d;
    logic                pos_valid_q;
    logic                pos_valid_d;
    logic                dir_q;
    logic                dir_d;
    logic                moved_q;
    logic                moved_d;
    logic                err_q;
    logic                err_d;
    logic [7:0]          rev_q;
    logic [7:0]          rev_d;
    logic [3:0]          pos_ext;
    logic [3:0]          cand_ext;
    logic                step_up;
    logic                step_down;

    // Free-running window counter; a reset restarts the window at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_q + 1'b1;
        end
    end

    assign win_end = (wcnt_q == {PWM_BITS{1'b1}});

    for (genvar g = 0; g < NUM_CH; g++) begin : g_meter
        pwm_duty_meter #(
            .PWM_BITS   (PWM_BITS),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_meter (
            .clk      (clk),
            .rst_n    (rst_n),
            .pwm_i    (pwm_in[g]),
            .win_end_i(win_end),
            .duty_o   (duty_w[g])
        );
    end

    assign duty_o = duty_w[duty_sel];

    // The duties are latched on the window-end edge, so they are new in the
    // cycle after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= win_end;
        end
    end

    // Classify every latched duty, count the peaks and remember which
    // channel holds the peak; optionally verify the shape around it.
    always_comb begin
        full_cnt = '0;
        cand_pos = '0;
        nbr_ok   = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            level[i] = classify(32'(duty_w[i]), FULL_MIN, MID_MIN);
            if (level[i] == LVL_FULL) begin
                full_cnt = full_cnt + 4'd1;
                cand_pos = 3'(i);
            end
        end
`ifdef NEIGHBOUR_CHECK_EN
        want = LVL_OFF;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == cand_pos) begin
                want = LVL_FULL;
            end else if ((4'(i) == {1'b0, cand_pos} + 4'd1) ||
                         (4'(i) + 4'd1 == {1'b0, cand_pos})) begin
                want = LVL_MID;
            end else begin
                want = LVL_OFF;
            end
            if (level[i] != want) begin
                nbr_ok = 1'b0;
            end
        end
`endif
    end

    assign frame_valid = (full_cnt == 4'd1) && nbr_ok;

    // Steps are compared one bit wider so that 7 and 0 are not adjacent.
    assign pos_ext   = {1'b0, pos_q};
    assign cand_ext  = {1'b0, cand_pos};
    assign step_up   = (cand_ext == pos_ext + 4'd1);
    assign step_down = (cand_ext + 4'd1 == pos_ext);

    // Tracker next state: only acts in the frame-done cycle, everything else
    // holds, and the pulse outputs default low.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        dir_d       = dir_q;
        moved_d     = 1'b0;
        err_d       = 1'b0;
        rev_d       = rev_q;
        if (frame_done_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_valid) begin
                        state_d     = ST_TRACK;
                        pos_d       = cand_pos;
                        pos_valid_d = 1'b1;
                        dir_d       = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (!frame_valid) begin
                        err_d       = 1'b1;
                        pos_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (cand_pos == pos_q) begin
                        state_d = ST_TRACK;
                    end else if (step_up) begin
                        pos_d   = cand_pos;
                        dir_d   = 1'b0;
                        moved_d = 1'b1;
                    end else if (step_down) begin
                        pos_d   = cand_pos;
                        dir_d   = 1'b1;
                        moved_d = 1'b1;
                    end else begin
                        err_d       = 1'b1;
                        pos_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (dir_d != dir_q) begin
            rev_d = rev_q + 8'd1;
        end
    end

    // Tracker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            moved_q     <= 1'b0;
            err_q       <= 1'b0;
            rev_q       <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            dir_q       <= dir_d;
            moved_q     <= moved_d;
            err_q       <= err_d;
            rev_q       <= rev_d;
        end
    end

    assign frame_done_o = frame_done_q;
    assign pos_o        = pos_q;
    assign pos_valid_o  = pos_valid_q;
    assign dir_o        = dir_q;
    assign moved_o      = moved_q;
    assign err_o        = err_q;
    assign reversals_o  = rev_q;

endmodule

// File: tb/tb_pwm_bargraph_decoder.sv
// Testbench for pwm_bargraph_decoder: drives window-aligned PWM patterns,
// predicts every output cycle from a frame-level model of the decoder's
// rules, and checks a hand-written table of directed frames.
module tb_pwm_bargraph_decoder;

    localparam int WIN  = 256;
    localparam int NCH  = 8;
    localparam int MAXW = 64;
    localparam int NTBL = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pwm_in = '0;
    logic [2:0]  duty_sel = '0;
    logic [7:0]  duty_o;
    logic        frame_done_o;
    logic [2:0]  pos_o;
    logic        pos_valid_o;
    logic        dir_o;
    logic        moved_o;
    logic        err_o;
    logic [7:0]  reversals_o;

    pwm_bargraph_decoder #(
        .PWM_BITS   (8),
        .SYNC_STAGES(2),
        .FULL_MIN   (200),
        .MID_MIN    (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .duty_sel    (duty_sel),
        .duty_o      (duty_o),
        .frame_done_o(frame_done_o),
        .pos_o       (pos_o),
        .pos_valid_o (pos_valid_o),
        .dir_o       (dir_o),
        .moved_o     (moved_o),
        .err_o       (err_o),
        .reversals_o (reversals_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][8:0] duty;
        logic [2:0]      sel;
        logic [7:0]      expDuty;
        logic            expValid;
        logic [2:0]      expPos;
        logic            expMoved;
        logic            expErr;
        logic            expDir;
        logic [7:0]      expRev;
    } vec_t;

    vec_t tbl [NTBL];
    int   frameDuty [MAXW][NCH];
    int   nWin;
    int   tbCyc;
    int   checks = 0;
    int   errors = 0;

    bit   mTrack;
    int   mPos;
    bit   mValid;
    bit   mDir;
    int   mRev;

    logic [23:0] actVec;
    assign actVec = {duty_o, frame_done_o, moved_o, err_o, pos_o, pos_valid_o, dir_o, reversals_o};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, tbCyc, act, exp);
        end
    endtask

    function automatic logic [7:0][8:0] pat(input int p);
        logic [7:0][8:0] d;
        d    = '0;
        d[p] = 9'd255;
        if (p > 0) d[p-1] = 9'd100;
        if (p < 7) d[p+1] = 9'd100;
        return d;
    endfunction

    function automatic vec_t mkVec(input logic [7:0][8:0] d, input int sel, input int expDuty,
                                   input bit v, input int pos, input bit mv, input bit er,
                                   input bit dr, input int rev);
        vec_t r;
        r.duty     = d;
        r.sel      = 3'(sel);
        r.expDuty  = 8'(expDuty);
        r.expValid = v;
        r.expPos   = 3'(pos);
        r.expMoved = mv;
        r.expErr   = er;
        r.expDir   = dr;
        r.expRev   = 8'(rev);
        return r;
    endfunction

    // Measured duty: fraction of the window the line was high, saturated.
    // The first window after reset loses its first two samples to the
    // synchroniser still holding reset zeros.
    function automatic int measDuty(input int w, input int ch);
        int c;
        c = frameDuty[w][ch];
        if (w == 0) c = (c > 2) ? c - 2 : 0;
        if (c > 255) c = 255;
        return c;
    endfunction

    function automatic int levelOf(input int d);
        return (d >= 200) ? 2 : (d >= 64) ? 1 : 0;
    endfunction

    // Frame-level decoder rules applied to window w.
    task automatic modelFrame(input int w, output bit mv, output bit er);
        int lv [NCH];
        int nFull;
        int p;
        bit ok;
        bit prevDir;
        nFull = 0;
        p = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            lv[ch] = levelOf(measDuty(w, ch));
            if (lv[ch] == 2) begin
                nFull++;
                p = ch;
            end
        end
        ok = (nFull == 1);
`ifdef NEIGHBOUR_CHECK_EN
        if (ok) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (lv[ch] != ((ch == p) ? 2 : ((ch == p - 1) || (ch == p + 1)) ? 1 : 0)) ok = 0;
            end
        end
`endif
        prevDir = mDir;
        mv = 0;
        er = 0;
        if (!mTrack) begin
            if (ok) begin
                mTrack = 1; mPos = p; mValid = 1; mDir = 0;
            end else begin
                er = 1;
            end
        end else if (!ok) begin
            er = 1; mValid = 0; mTrack = 0;
        end else if (p == mPos + 1) begin
            mDir = 0; mv = 1; mPos = p;
        end else if (p == mPos - 1) begin
            mDir = 1; mv = 1; mPos = p;
        end else if (p != mPos) begin
            er = 1; mValid = 0; mTrack = 0;
        end
        if (mDir != prevDir) mRev = (mRev + 1) % 256;
    endtask

    // Drive the PWM phase that the synchronised lines will show two cycles
    // later, so that source windows line up with the decoder's windows.
    task automatic applyStimulus(input bit useTable);
        int ph;
        int w;
        int nxt;
        ph  = (tbCyc + 2) % WIN;
        w   = (tbCyc + 2) / WIN;
        nxt = tbCyc + 1;
        for (int ch = 0; ch < NCH; ch++) begin
            pwm_in[ch] = (w < nWin) && (ph < frameDuty[w][ch]);
        end
        if (useTable && (nxt % WIN == 1) && (nxt > WIN) && (nxt / WIN - 1 < NTBL)) begin
            duty_sel = tbl[nxt / WIN - 1].sel;
        end else begin
            duty_sel = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic runScenario(input int n, input bit useTable);
        bit expMv;
        bit expEr;
        bit fdBefore;
        int w;
        int expD;
        logic [23:0] expVec;
        nWin = n;
        mTrack = 0; mPos = 0; mValid = 0; mDir = 0; mRev = 0;
        fdBefore = 0;
        tbCyc = 0;
        rst_n = 1'b1;
        applyStimulus(useTable);
        while (tbCyc < n * WIN + 2) begin
            @(negedge clk);
            tbCyc++;
            expMv = 0;
            expEr = 0;
            w = tbCyc / WIN - 1;
            if ((tbCyc % WIN == 1) && (tbCyc > WIN)) modelFrame(w, expMv, expEr);
            expD   = (tbCyc >= WIN) ? measDuty(tbCyc / WIN - 1, int'(duty_sel)) : 0;
            expVec = {8'(expD), (tbCyc % WIN == 0), expMv, expEr, 3'(mPos), mValid, mDir, 8'(mRev)};
            checkOutput("outputs", 32'(actVec), 32'(expVec));
            if (tbCyc == WIN - 1) fdBefore = frame_done_o;
            if (tbCyc == WIN) checkOutput("first_frame_done_257th_cycle", 32'({fdBefore, frame_done_o}), 32'(2'b01));
            if (useTable && (tbCyc % WIN == 1) && (tbCyc > WIN)) begin
                checkOutput("tbl_duty", 32'(duty_o), 32'(tbl[w].expDuty));
                checkOutput("tbl_pos", 32'({pos_valid_o, pos_o}), 32'({tbl[w].expValid, tbl[w].expPos}));
                checkOutput("tbl_pulse", 32'({moved_o, err_o}), 32'({tbl[w].expMoved, tbl[w].expErr}));
                checkOutput("tbl_dir_rev", 32'({dir_o, reversals_o}), 32'({tbl[w].expDir, tbl[w].expRev}));
            end
            applyStimulus(useTable);
        end
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic applyReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_clears", 32'(actVec), 32'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic setPat(input int w, input int p);
        frameDuty[w][p] = int'($urandom_range(200, 256));
        if (p > 0) frameDuty[w][p-1] = int'($urandom_range(64, 199));
        if (p < 7) frameDuty[w][p+1] = int'($urandom_range(64, 199));
    endtask

    task automatic genRandom(input int n);
        int cur;
        int r;
        int np;
        int a;
        cur = int'($urandom_range(0, 7));
        for (int w = 0; w < n; w++) begin
            for (int ch = 0; ch < NCH; ch++) frameDuty[w][ch] = int'($urandom_range(0, 63));
            r = int'($urandom_range(0, 99));
            if (r < 65) begin
                np = cur + int'($urandom_range(0, 2)) - 1;
                if (np < 0) np = 0;
                if (np > 7) np = 7;
                setPat(w, np);
                if ($urandom_range(0, 9) == 0) frameDuty[w][$urandom_range(0, 7)] = int'($urandom_range(64, 199));
                cur = np;
            end else if (r < 78) begin
                cur = int'($urandom_range(0, 7));
                setPat(w, cur);
            end else if (r < 90) begin
                a = int'($urandom_range(0, 7));
                frameDuty[w][a] = int'($urandom_range(200, 256));
                frameDuty[w][(a + 1 + int'($urandom_range(0, 6))) % NCH] = int'($urandom_range(200, 256));
            end else begin
                for (int ch = 0; ch < NCH; ch++) frameDuty[w][ch] = int'($urandom_range(0, 256));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0][8:0] d;

        // Directed frames: {duties, duty_sel, expected duty, valid, pos, moved, err, dir, reversals}
        tbl[0] = mkVec(pat(3), 2, 98, 1, 3, 0, 0, 0, 0);
        tbl[1] = mkVec(pat(3), 3, 255, 1, 3, 0, 0, 0, 0);
        tbl[2] = mkVec(pat(4), 5, 100, 1, 4, 1, 0, 0, 0);
        tbl[3] = mkVec(pat(3), 2, 100, 1, 3, 1, 0, 1, 1);
        d = '0; d[1] = 9'd255; d[5] = 9'd255;
        tbl[4] = mkVec(d, 1, 255, 0, 3, 0, 1, 1, 1);
        tbl[5] = mkVec(pat(2), 1, 100, 1, 2, 0, 0, 0, 2);
        tbl[6] = mkVec(pat(5), 4, 100, 0, 2, 0, 1, 0, 2);
        d = '0; d[6] = 9'd256; d[5] = 9'd100; d[7] = 9'd100;
        tbl[7] = mkVec(d, 6, 255, 1, 6, 0, 0, 0, 2);
        tbl[8] = mkVec(pat(7), 7, 255, 1, 7, 1, 0, 0, 2);
        tbl[9] = mkVec(pat(0), 0, 255, 0, 7, 0, 1, 0, 2);
`ifdef NEIGHBOUR_CHECK_EN
        d = pat(3); d[6] = 9'd100;
        tbl[10] = mkVec(d, 6, 100, 0, 7, 0, 1, 0, 2);
        d = '0; d[4] = 9'd200; d[3] = 9'd64; d[5] = 9'd63;
        tbl[11] = mkVec(d, 5, 63, 0, 7, 0, 1, 0, 2);
        d = pat(3); d[4] = 9'd199;
        tbl[12] = mkVec(d, 4, 199, 1, 3, 0, 0, 0, 2);
        tbl[13] = mkVec('0, 3, 0, 0, 3, 0, 1, 0, 2);
`else
        d = pat(3); d[6] = 9'd100;
        tbl[10] = mkVec(d, 6, 100, 1, 3, 0, 0, 0, 2);
        d = '0; d[4] = 9'd200; d[3] = 9'd64; d[5] = 9'd63;
        tbl[11] = mkVec(d, 5, 63, 1, 4, 1, 0, 0, 2);
        d = pat(3); d[4] = 9'd199;
        tbl[12] = mkVec(d, 4, 199, 1, 3, 1, 0, 1, 3);
        tbl[13] = mkVec('0, 3, 0, 0, 3, 0, 1, 1, 3);
`endif

        tbCyc = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 32'(actVec), 32'(0));

        $display("[TB] directed table");
        for (int i = 0; i < NTBL; i++) begin
            for (int ch = 0; ch < NCH; ch++) frameDuty[i][ch] = int'(tbl[i].duty[ch]);
        end
        runScenario(NTBL, 1'b1);

        $display("[TB] mid-window reset then random frames");
        applyReset();
        genRandom(40);
        runScenario(40, 1'b0);

        applyReset();
        genRandom(20);
        runScenario(20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
